// File: rtl/latch_gate_seq.sv
// Latch-bank gate sequencer: presets the bank or writes one word through a
// SETUP / OPEN / HOLD gate window. Define LATCH_GATE_SEQ_SHADOW_EN to model the latch contents on SHADOW_Q.
module latch_gate_seq #(
  parameter int   WIDTH            = 8,
  parameter int   SETUP_CYC        = 1,
  parameter int   OPEN_CYC         = 2,
  parameter int   HOLD_CYC         = 1,
  parameter int   PRESET_CYC       = 1,
  parameter logic IS_G_INVERTED    = 1'b0,
  parameter logic IS_PRE_INVERTED  = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             PRE_REQ,
  output logic [WIDTH-1:0] LD_D,
  output logic             LD_G,
  output logic             LD_GE,
  output logic             LD_PRE,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SHADOW_Q
);

  // Counter reload value for a phase of n cycles; 0 behaves as 1.
  function automatic logic [7:0] phase_load(input int n);
    return (n <= 1) ? 8'd0 : 8'(n - 1);
  endfunction

  localparam logic [7:0] SETUP_LD  = phase_load(SETUP_CYC);
  localparam logic [7:0] OPEN_LD   = phase_load(OPEN_CYC);
  localparam logic [7:0] HOLD_LD   = phase_load(HOLD_CYC);
  localparam logic [7:0] PRESET_LD = phase_load(PRESET_CYC);

  typedef enum logic [2:0] {IDLE, PRESET, SETUP, OPEN, HOLD} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       accept;

  assign IN_READY = (state == IDLE) && !PRE_REQ && !R;
  assign accept   = IN_READY && IN_VALID;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
    unique case (state)
      IDLE: begin
        if (PRE_REQ) begin
          state_nxt = PRESET;
          cnt_nxt   = PRESET_LD;
        end else if (IN_VALID) begin
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      PRESET: if (cnt == 8'd0) state_nxt = IDLE;
      SETUP: begin
        if (cnt == 8'd0) begin
          state_nxt = OPEN;
          cnt_nxt   = OPEN_LD;
        end
      end
      OPEN: begin
        if (cnt == 8'd0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
        end
      end
      HOLD: if (cnt == 8'd0) state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Pin outputs are registered from the next state so they line up with it.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge C) begin
    if (R) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      LD_D   <= '0;
      LD_GE  <= 1'b0;
      LD_G   <= IS_G_INVERTED;
      LD_PRE <= IS_PRE_INVERTED;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      if (accept) LD_D <= IN_DATA;
      LD_GE  <= (state_nxt == SETUP) || (state_nxt == OPEN) || (state_nxt == HOLD);
      LD_G   <= (state_nxt == OPEN) ^ IS_G_INVERTED;
      LD_PRE <= (state_nxt == PRESET) ^ IS_PRE_INVERTED;
      BUSY   <= (state_nxt != IDLE);
      DONE   <= ((state == PRESET) || (state == HOLD)) && (state_nxt == IDLE);
    end
  end

`ifdef LATCH_GATE_SEQ_SHADOW_EN
  logic [WIDTH-1:0] shadow_q;

  // The bank takes all ones when a preset ends and LD_D when the gate closes.
  always_ff @(posedge C) begin
    if (R) begin
      shadow_q <= '0;
    end else if ((state == PRESET) && (state_nxt == IDLE)) begin
      shadow_q <= '1;
    end else if ((state == OPEN) && (state_nxt == HOLD)) begin
      shadow_q <= LD_D;
    end
  end

  assign SHADOW_Q = shadow_q;
`else
  assign SHADOW_Q = '0;
`endif

endmodule

// File: tb/tb_latch_gate_seq.sv
// Randomized bench for latch_gate_seq: two instances (default and inverted/short
// phases) checked every cycle against a phase-schedule model, plus literal checks.
module tb_latch_gate_seq;

  typedef enum int {OP_NONE, OP_PRE, OP_WR} op_e;
  typedef struct {
    op_e        op;
    int         t;
    logic [7:0] ld_d;
    logic [7:0] shadow;
    bit         done;
  } model_t;

`ifdef LATCH_GATE_SEQ_SHADOW_EN
  localparam bit SH_EN = 1'b1;
`else
  localparam bit SH_EN = 1'b0;
`endif

  // Effective phase lengths (0 counts as 1) and polarities for each instance.
  int s_n[2] = '{1, 1};
  int o_n[2] = '{2, 1};
  int h_n[2] = '{1, 1};
  int p_n[2] = '{1, 3};
  bit g_inv[2] = '{1'b0, 1'b1};
  bit p_inv[2] = '{1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       R = 1'b1;
  logic       IN_VALID = 1'b0;
  logic       PRE_REQ = 1'b0;
  logic [7:0] IN_DATA = 8'h00;

  logic [1:0] rdy, ld_g, ld_ge, ld_pre, busy, done;
  logic [7:0] ld_d [2];
  logic [7:0] shadow [2];

  model_t m[2];
  int     tests = 0;
  int     fails = 0;
  bit     checking = 1'b0;

  always #5 clk = ~clk;

  latch_gate_seq u_dut0 (
    .C(clk), .R(R), .IN_VALID(IN_VALID), .IN_READY(rdy[0]), .IN_DATA(IN_DATA),
    .PRE_REQ(PRE_REQ), .LD_D(ld_d[0]), .LD_G(ld_g[0]), .LD_GE(ld_ge[0]),
    .LD_PRE(ld_pre[0]), .BUSY(busy[0]), .DONE(done[0]), .SHADOW_Q(shadow[0])
  );

  latch_gate_seq #(
    .WIDTH(8), .SETUP_CYC(0), .OPEN_CYC(0), .HOLD_CYC(0), .PRESET_CYC(3),
    .IS_G_INVERTED(1'b1), .IS_PRE_INVERTED(1'b1)
  ) u_dut1 (
    .C(clk), .R(R), .IN_VALID(IN_VALID), .IN_READY(rdy[1]), .IN_DATA(IN_DATA),
    .PRE_REQ(PRE_REQ), .LD_D(ld_d[1]), .LD_G(ld_g[1]), .LD_GE(ld_ge[1]),
    .LD_PRE(ld_pre[1]), .BUSY(busy[1]), .DONE(done[1]), .SHADOW_Q(shadow[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m[i] = '{op: OP_NONE, t: 0, ld_d: 8'h00, shadow: 8'h00, done: 1'b0};
  endtask

  // Advance one instance's model across the coming clock edge.
  task automatic model_step(input int i, input bit v, input bit p, input logic [7:0] d, input bit r);
    int len;
    if (r) begin
      model_reset(i);
    end else if (m[i].op == OP_NONE) begin
      m[i].done = 1'b0;
      if (p) begin
        m[i].op = OP_PRE;
        m[i].t  = 1;
      end else if (v) begin
        m[i].op   = OP_WR;
        m[i].t    = 1;
        m[i].ld_d = d;
      end
    end else begin
      len = (m[i].op == OP_PRE) ? p_n[i] : s_n[i] + o_n[i] + h_n[i];
      m[i].done = 1'b0;
      if (SH_EN && m[i].op == OP_WR && m[i].t == s_n[i] + o_n[i]) m[i].shadow = m[i].ld_d;
      if (m[i].t == len) begin
        if (SH_EN && m[i].op == OP_PRE) m[i].shadow = 8'hFF;
        m[i].op   = OP_NONE;
        m[i].done = 1'b1;
      end else begin
        m[i].t++;
      end
    end
  endtask

  task automatic compare_dut(input int i);
    bit wr, g_act;
    wr    = (m[i].op == OP_WR);
    g_act = wr && (m[i].t > s_n[i]) && (m[i].t <= s_n[i] + o_n[i]);
    check($sformatf("dut%0d busy", i), 32'(busy[i]), 32'(m[i].op != OP_NONE));
    check($sformatf("dut%0d ld_ge", i), 32'(ld_ge[i]), 32'(wr));
    check($sformatf("dut%0d ld_g", i), 32'(ld_g[i]), 32'(g_act ^ g_inv[i]));
    check($sformatf("dut%0d ld_pre", i), 32'(ld_pre[i]), 32'((m[i].op == OP_PRE) ^ p_inv[i]));
    check($sformatf("dut%0d done", i), 32'(done[i]), 32'(m[i].done));
    check($sformatf("dut%0d ld_d", i), 32'(ld_d[i]), 32'(m[i].ld_d));
    check($sformatf("dut%0d shadow_q", i), 32'(shadow[i]), 32'(m[i].shadow));
  endtask

  always @(negedge clk) begin
    if (checking) begin
      compare_dut(0);
      compare_dut(1);
    end
  end

  task automatic wait_cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input bit p, input logic [7:0] d, input bit r);
    IN_VALID = v;
    PRE_REQ  = p;
    IN_DATA  = d;
    R        = r;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d in_ready", i), 32'(rdy[i]), 32'(!r && !p && m[i].op == OP_NONE));
      model_step(i, v, p, d, r);
    end
  endtask

  // {BUSY, LD_GE, LD_G, DONE} for cycles 1..5 after accepting a write.
  logic [3:0] lit0 [5] = '{4'b1100, 4'b1110, 4'b1110, 4'b1100, 4'b0001};
  logic [3:0] lit1 [5] = '{4'b1110, 4'b1100, 4'b1110, 4'b0011, 4'b0010};

  initial begin
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    checking = 1'b1;
    wait_cyc();
    check("reset dut0 ld_g", 32'(ld_g[0]), 32'd0);
    check("reset dut1 ld_g", 32'(ld_g[1]), 32'd1);
    check("reset dut1 ld_pre", 32'(ld_pre[1]), 32'd1);
    check("reset dut0 in_ready", 32'(rdy[0]), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);

    // Single write of A5 through both instances.
    wait_cyc();
    drive(1'b1, 1'b0, 8'hA5, 1'b0);
    for (int c = 0; c < 5; c++) begin
      wait_cyc();
      check($sformatf("write dut0 c%0d", c + 1), 32'({busy[0], ld_ge[0], ld_g[0], done[0]}), 32'(lit0[c]));
      check($sformatf("write dut1 c%0d", c + 1), 32'({busy[1], ld_ge[1], ld_g[1], done[1]}), 32'(lit1[c]));
      check($sformatf("write dut0 ld_d c%0d", c + 1), 32'(ld_d[0]), 32'hA5);
      drive(1'b0, 1'b0, 8'($urandom), 1'b0);
    end

    // Preset and write requested together: preset wins, write stays pending.
    wait_cyc();
    drive(1'b1, 1'b1, 8'hA5, 1'b0);
    check("collide dut0 in_ready", 32'(rdy[0]), 32'd0);
    wait_cyc();
    check("preset dut0 ld_pre", 32'(ld_pre[0]), 32'd1);
    check("preset dut1 ld_pre", 32'(ld_pre[1]), 32'd0);
    drive(1'b1, 1'b0, 8'hA5, 1'b0);
    wait_cyc();
    check("preset dut0 done", 32'(done[0]), 32'd1);
    check("preset dut0 busy", 32'(busy[0]), 32'd0);
    check("preset dut0 shadow", 32'(shadow[0]), SH_EN ? 32'hFF : 32'h00);
    drive(1'b1, 1'b0, 8'hA5, 1'b0);
    check("pending dut0 in_ready", 32'(rdy[0]), 32'd1);
    repeat (8) begin
      wait_cyc();
      drive(1'b0, 1'b0, 8'h00, 1'b0);
    end

    // Reset during the second OPEN cycle of dut0 aborts without DONE.
    wait_cyc();
    drive(1'b1, 1'b0, 8'h3C, 1'b0);
    repeat (2) begin
      wait_cyc();
      drive(1'b0, 1'b0, 8'h00, 1'b0);
    end
    wait_cyc();
    check("abort pre dut0 ld_g", 32'(ld_g[0]), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    wait_cyc();
    check("abort dut0 state", 32'({busy[0], ld_ge[0], ld_g[0], done[0]}), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    wait_cyc();
    check("abort dut0 no done", 32'(done[0]), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Random traffic.
    repeat (600) begin
      wait_cyc();
      drive(1'($urandom), ($urandom % 8) == 0, 8'($urandom), ($urandom % 60) == 0);
    end
    repeat (10) begin
      wait_cyc();
      drive(1'b0, 1'b0, 8'h00, 1'b0);
    end
    wait_cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
